conv_unit_par: RTL and testbench
================================

Name: conv_unit_par

Overview:
Parametrised successor convolution engine. Computes one output pixel as the fp16 dot product of a D×F×F image window and filter, plus bias.
- Uses P parallel MAC lanes and a start/done handshake.
- Repeatable without reset.
- Sits between the window/line-buffer stage and the activation/pooling stage of the conv layer.

Parameters:
DATA_WIDTH, 16, element width; fp16 (1/5/10) arithmetic only, other values unsupported.
D, 1, input channel depth.
F, 5, filter side length.
P, 1, parallel MAC lanes (1..D*F*F).

Ports:
clk  in  1  clock, rising edge.
reset  in  1  asynchronous, active-high.
start  in  1  one-cycle request; sampled only in IDLE.
image  in  D*F*F*DATA_WIDTH  window, element 0 in MSB slice ([0:...] big-endian packing).
filter  in  D*F*F*DATA_WIDTH  weights, same packing.
bias  in  DATA_WIDTH  fp16 bias added once.
busy  out  1  high from cycle after accepted start until done.
done  out  1  one-cycle pulse, result valid.
result  out  DATA_WIDTH  fp16 sum, held until next accepted start completes.

Behaviour:
- Reset values: all outputs 0, state IDLE, all accumulators 0.
- Derived constants: N = D*F*F; B = ceil(N/P) beats.
- start accepted in IDLE at edge k:
  - image, filter and bias are copied into internal registers.
  - Inputs may change afterwards.
- States:
  - IDLE -> RUN on start.
  - RUN, B cycles. Beat b feeds lane j element b*P+j. Indices ≥ N feed 0×0 (zero padding). Each lane acc += a*w.
  - REDUCE, P cycles. Tree register starts at bias, then adds lane 0..P-1 partials sequentially.
  - DONE, 1 cycle: done=1, result updated, busy=0. Then IDLE.
- Latency:
  - busy=1 from edge k+1 through cycle before done.
  - done high in cycle after edge k+B+P+1, i.e. B+P+2 cycles after start.
  - Default parameters (B=25, P=1): 28 cycles.
- start outside IDLE is ignored, including in DONE. Back-to-back issue is possible from the cycle after done.
- Accumulators clear on entering RUN. No residue from a previous pixel.
- Arithmetic:
  - fp16 multiply and add, each rounded to nearest-even.
  - Subnormal inputs and results are flushed to +0.
  - Inf/NaN propagate (NaN result = 0x7E00).
  - Summation order is fixed as above; results must be bit-exact to a model using the same order.
- Reset mid-operation: immediate return to IDLE, busy=0, done=0, result=0, accumulators cleared.
- Reset during start: reset wins.

Decomposition:
- Shared package conv_pkg:
  - FP16 constants (FP16_ZERO 0x0000, FP16_ONE 0x3C00, FP16_QNAN 0x7E00).
  - State enum typedef (IDLE/RUN/REDUCE/DONE).
  - Helper function for ceil division.
- Sub-module conv_mac_lane:
  - Ports clk, reset, clear, en, a, w, acc.
  - Contains the fp16 multiplier and adder with a registered accumulator, 1-cycle update.
  - Instantiated P times. The REDUCE adder reuses the same fp16 adder function.

Test Plan:
- Defaults, image all 0x3C00, filter all 0x3C00, bias 0x0000, start -> done pulse 28 cycles after start, result 0x4E40 (25.0), busy high 26 cycles.
- P=5, same stimulus, bias 0x3800 (0.5) -> result 0x4E60 (25.5), done at B+P+2=12 cycles.
- P=2 (N=25, odd padding), image one-hot element 24 = 0x4000, filter all 0x3C00 -> result 0x4000. Confirms the padded lane contributes 0.
- Start pulsed again mid-RUN and in DONE cycle -> ignored, single done, result unchanged; then second start with filter all 0x0000 -> result 0x0000, confirming accumulators cleared.
- Reset asserted 10 cycles into RUN -> busy/done/result 0 same cycle; a following start yields the correct fresh result.
- Image element 0 = 0x7C00 (inf), filter element 0 = 0x0000 -> result 0x7E00. Image element 0 = 0x0001 (subnormal), rest 0, filter 0x3C00 -> result 0x0000.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared fp16 helpers, constants and FSM state type for the convolution engine.
// fp16 ops round to nearest-even, flush subnormals to +0 and return +0 for every zero result.
package conv_pkg;

    localparam int          FP16_W    = 16;
    localparam logic [15:0] FP16_ZERO = 16'h0000;
    localparam logic [15:0] FP16_ONE  = 16'h3C00;
    localparam logic [15:0] FP16_QNAN = 16'h7E00;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_REDUCE,
        ST_DONE
    } state_t;

    function automatic int ceil_div(input int num, input int den);
        return (num + den - 1) / den;
    endfunction

    function automatic logic [15:0] fp16_mul(input logic [15:0] a, input logic [15:0] b);
        logic        so;
        logic        a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
        logic [21:0] prod;
        logic [10:0] mant;
        logic        g, s;
        int          e;
        logic [15:0] r;
        so     = a[15] ^ b[15];
        a_zero = (a[14:10] == 5'd0);
        b_zero = (b[14:10] == 5'd0);
        a_inf  = (a[14:10] == 5'h1F) && (a[9:0] == 10'd0);
        b_inf  = (b[14:10] == 5'h1F) && (b[9:0] == 10'd0);
        a_nan  = (a[14:10] == 5'h1F) && (a[9:0] != 10'd0);
        b_nan  = (b[14:10] == 5'h1F) && (b[9:0] != 10'd0);
        prod   = 22'({1'b1, a[9:0]}) * 22'({1'b1, b[9:0]});
        e      = int'(a[14:10]) + int'(b[14:10]) - 15;
        if (prod[21]) begin
            mant = prod[21:11];
            g    = prod[10];
            s    = |prod[9:0];
            e    = e + 1;
        end else begin
            mant = prod[20:10];
            g    = prod[9];
            s    = |prod[8:0];
        end
        if (g && (s || mant[0])) begin
            if (&mant) begin
                mant = 11'h400;
                e    = e + 1;
            end else begin
                mant = mant + 11'd1;
            end
        end
        if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) r = FP16_QNAN;
        else if (a_inf || b_inf)                                       r = {so, 5'h1F, 10'd0};
        else if (a_zero || b_zero)                                     r = FP16_ZERO;
        else if (e >= 31)                                              r = {so, 5'h1F, 10'd0};
        else if (e <= 0)                                               r = FP16_ZERO;
        else                                                           r = {so, e[4:0], mant[9:0]};
        return r;
    endfunction

    function automatic logic [15:0] fp16_add(input logic [15:0] a, input logic [15:0] b);
        logic        a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
        logic        swap, sx;
        logic [4:0]  ex, ey;
        logic [9:0]  fx, fy;
        logic [13:0] mx, my, m;
        logic [14:0] sum;
        logic [10:0] mant;
        int          d, e;
        logic [15:0] r;
        a_zero = (a[14:10] == 5'd0);
        b_zero = (b[14:10] == 5'd0);
        a_inf  = (a[14:10] == 5'h1F) && (a[9:0] == 10'd0);
        b_inf  = (b[14:10] == 5'h1F) && (b[9:0] == 10'd0);
        a_nan  = (a[14:10] == 5'h1F) && (a[9:0] != 10'd0);
        b_nan  = (b[14:10] == 5'h1F) && (b[9:0] != 10'd0);
        r      = FP16_ZERO;
        if (a_nan || b_nan || (a_inf && b_inf && (a[15] != b[15]))) r = FP16_QNAN;
        else if (a_inf)              r = {a[15], 5'h1F, 10'd0};
        else if (b_inf)              r = {b[15], 5'h1F, 10'd0};
        else if (a_zero && b_zero)   r = FP16_ZERO;
        else if (a_zero)             r = b;
        else if (b_zero)             r = a;
        else begin
            // Order operands by magnitude so the subtract path never goes negative.
            swap = (b[14:10] > a[14:10]) || ((b[14:10] == a[14:10]) && (b[9:0] > a[9:0]));
            sx   = swap ? b[15]    : a[15];
            ex   = swap ? b[14:10] : a[14:10];
            ey   = swap ? a[14:10] : b[14:10];
            fx   = swap ? b[9:0]   : a[9:0];
            fy   = swap ? a[9:0]   : b[9:0];
            mx   = {1'b1, fx, 3'b000};
            my   = {1'b1, fy, 3'b000};
            d    = int'(ex) - int'(ey);
            e    = int'(ex);
            if (d > 13)     my = 14'd1;
            else if (d > 0) my = (my >> d) | {13'd0, |(my & ((14'd1 << d) - 14'd1))};
            if (a[15] == b[15]) begin
                sum = {1'b0, mx} + {1'b0, my};
                if (sum[14]) begin
                    m = sum[14:1] | {13'd0, sum[0]};
                    e = e + 1;
                end else begin
                    m = sum[13:0];
                end
            end else begin
                m = mx - my;
                for (int i = 0; i < 13; i++) begin
                    if (!m[13] && (m != 14'd0)) begin
                        m = m << 1;
                        e = e - 1;
                    end
                end
            end
            mant = m[13:3];
            if (m[2] && ((|m[1:0]) || mant[0])) begin
                if (&mant) begin
                    mant = 11'h400;
                    e    = e + 1;
                end else begin
                    mant = mant + 11'd1;
                end
            end
            if (m == 14'd0)   r = FP16_ZERO;
            else if (e >= 31) r = {sx, 5'h1F, 10'd0};
            else if (e <= 0)  r = FP16_ZERO;
            else              r = {sx, e[4:0], mant[9:0]};
        end
        return r;
    endfunction

endpackage

// File: rtl/conv_mac_lane.sv
// One fp16 multiply-accumulate lane; acc updates one cycle after en.
module conv_mac_lane
    import conv_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              en,
    input  logic [FP16_W-1:0] a,
    input  logic [FP16_W-1:0] w,
    output logic [FP16_W-1:0] acc
);

    logic [FP16_W-1:0] r_acc;

    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)      r_acc <= FP16_ZERO;
        else if (clear) r_acc <= FP16_ZERO;
        else if (en)    r_acc <= fp16_add(r_acc, fp16_mul(a, w));
    end

    assign acc = r_acc;

endmodule

// File: rtl/conv_unit_par.sv
// fp16 convolution pixel engine: P MAC lanes over ceil(N/P) beats, then a serial
// bias-first reduction of the lane partials.
module conv_unit_par
    import conv_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int D          = 1,
    parameter int F          = 5,
    parameter int P          = 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic [D*F*F*DATA_WIDTH-1:0] image,
    input  logic [D*F*F*DATA_WIDTH-1:0] filter,
    input  logic [DATA_WIDTH-1:0]       bias,
    output logic                        busy,
    output logic                        done,
    output logic [DATA_WIDTH-1:0]       result
);

    localparam int N     = D * F * F;
    localparam int B     = ceil_div(N, P);
    localparam int SHIFT = P * DATA_WIDTH;
    localparam int MAXC  = (B > P) ? B : P;
    localparam int CNT_W = (MAXC > 1) ? $clog2(MAXC) : 1;

    state_t                  r_state, w_next;
    logic [N*DATA_WIDTH-1:0] r_img, r_flt;
    logic [DATA_WIDTH-1:0]   r_bias, r_tree, r_result;
    logic [CNT_W-1:0]        r_cnt;
    logic                    r_busy, r_done;

    logic                    w_capture, w_clear, w_en, w_reduce, w_last_beat, w_last_lane;
    logic [DATA_WIDTH-1:0]   w_acc [P];
    logic [DATA_WIDTH-1:0]   w_lane, w_sum;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        w_next      = r_state;
        w_capture   = 1'b0;
        w_clear     = 1'b0;
        w_en        = 1'b0;
        w_reduce    = 1'b0;
        w_last_beat = 1'b0;
        w_last_lane = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next    = ST_RUN;
                    w_capture = 1'b1;
                end
            end
            ST_RUN: begin
                // First RUN cycle only clears the lanes; beats follow once busy is up.
                if (!r_busy) begin
                    w_clear = 1'b1;
                end else begin
                    w_en = 1'b1;
                    if (r_cnt == CNT_W'(B - 1)) begin
                        w_last_beat = 1'b1;
                        w_next      = ST_REDUCE;
                    end
                end
            end
            ST_REDUCE: begin
                w_reduce = 1'b1;
                if (r_cnt == CNT_W'(P - 1)) begin
                    w_last_lane = 1'b1;
                    w_next      = ST_DONE;
                end
            end
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_lane = FP16_ZERO;
        for (int j = 0; j < P; j++) begin
            if (r_cnt == CNT_W'(j)) w_lane = w_acc[j];
        end
    end

    assign w_sum = fp16_add(r_tree, w_lane);

    // NOTE: the operand windows are pure data, so they carry no reset; the
    // left shift zero-fills, which supplies the padding elements past N.
    always_ff @(posedge clk) begin
        if (w_capture) begin
            r_img  <= image;
            r_flt  <= filter;
            r_bias <= bias;
        end else if (w_en) begin
            r_img <= r_img << SHIFT;
            r_flt <= r_flt << SHIFT;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_result <= FP16_ZERO;
            r_tree   <= FP16_ZERO;
            r_cnt    <= '0;
        end else begin
            r_done <= 1'b0;
            if (w_clear) begin
                r_busy <= 1'b1;
                r_cnt  <= '0;
            end
            if (w_en) begin
                if (w_last_beat) begin
                    r_cnt  <= '0;
                    r_tree <= r_bias;
                end else begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end
            if (w_reduce) begin
                if (w_last_lane) begin
                    r_result <= w_sum;
                    r_done   <= 1'b1;
                    r_busy   <= 1'b0;
                    r_cnt    <= '0;
                end else begin
                    r_tree <= w_sum;
                    r_cnt  <= r_cnt + CNT_W'(1);
                end
            end
        end
    end

    for (genvar j = 0; j < P; j++) begin : g_lane
        conv_mac_lane u_lane (
            .clk   (clk),
            .reset (reset),
            .clear (w_clear),
            .en    (w_en),
            .a     (r_img[(N-1-j)*DATA_WIDTH +: DATA_WIDTH]),
            .w     (r_flt[(N-1-j)*DATA_WIDTH +: DATA_WIDTH]),
            .acc   (w_acc[j])
        );
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign result = r_result;

endmodule

// File: tb/tb_conv_unit_par.sv
// Directed bench for conv_unit_par: three instances (P=1, 5, 2) driven from a vector
// table, plus hand sequences for ignored starts, accumulator clearing and mid-run reset.
module tb_conv_unit_par;

    localparam int N = 25;
    localparam int W = 16;

    typedef logic [N*W-1:0] win_t;

    typedef struct {
        int          sel;
        win_t        img;
        win_t        flt;
        logic [15:0] bs;
        logic [15:0] res;
        int          lat;
        string       name;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  start_v;
    win_t        image, filter;
    logic [15:0] bias;
    logic [2:0]  busy_v, done_v;
    logic [15:0] res_v [3];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    conv_unit_par #(.DATA_WIDTH(16), .D(1), .F(5), .P(1)) dut_p1 (
        .clk(clk), .reset(reset), .start(start_v[0]), .image(image), .filter(filter),
        .bias(bias), .busy(busy_v[0]), .done(done_v[0]), .result(res_v[0]));

    conv_unit_par #(.DATA_WIDTH(16), .D(1), .F(5), .P(5)) dut_p5 (
        .clk(clk), .reset(reset), .start(start_v[1]), .image(image), .filter(filter),
        .bias(bias), .busy(busy_v[1]), .done(done_v[1]), .result(res_v[1]));

    conv_unit_par #(.DATA_WIDTH(16), .D(1), .F(5), .P(2)) dut_p2 (
        .clk(clk), .reset(reset), .start(start_v[2]), .image(image), .filter(filter),
        .bias(bias), .busy(busy_v[2]), .done(done_v[2]), .result(res_v[2]));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic win_t fill(input logic [15:0] v);
        win_t w;
        for (int i = 0; i < N; i++) w[i*W +: W] = v;
        return w;
    endfunction

    function automatic win_t onehot(input int idx, input logic [15:0] v);
        win_t w;
        w = '0;
        w[(N-1-idx)*W +: W] = v;
        return w;
    endfunction

    function automatic vec_t mk(input int sel, input win_t img, input win_t flt,
                                input logic [15:0] bs, input logic [15:0] res,
                                input int lat, input string name);
        vec_t v;
        v.sel = sel; v.img = img; v.flt = flt; v.bs = bs;
        v.res = res; v.lat = lat; v.name = name;
        return v;
    endfunction

    // Entered and left at posedge+1; issues one start and follows it to the done pulse.
    task automatic run_op(input int sel, input win_t img, input win_t flt, input logic [15:0] bs,
                          input logic [15:0] exp_res, input int exp_lat, input string name);
        int cyc, bcnt;
        bit seen;
        image  = img;
        filter = flt;
        bias   = bs;
        start_v[sel] = 1'b1;
        @(posedge clk); #1;
        start_v[sel] = 1'b0;
        cyc  = 1;
        bcnt = 0;
        seen = 1'b0;
        while (!seen && cyc < 200) begin
            if (done_v[sel]) begin
                seen = 1'b1;
            end else begin
                if (busy_v[sel]) bcnt++;
                @(posedge clk); #1;
                cyc++;
            end
        end
        check({name, " done seen"}, 32'(seen), 32'd1);
        check({name, " latency"}, 32'(cyc), 32'(exp_lat));
        check({name, " busy cycles"}, 32'(bcnt), 32'(exp_lat - 2));
        check({name, " busy low at done"}, 32'(busy_v[sel]), 32'd0);
        check({name, " result"}, 32'(res_v[sel]), 32'(exp_res));
        @(posedge clk); #1;
        check({name, " done one cycle"}, 32'(done_v[sel]), 32'd0);
        check({name, " result held"}, 32'(res_v[sel]), 32'(exp_res));
    endtask

    vec_t vecs [10];

    initial begin
        int cyc, bcnt, dcnt, done_cyc;

        vecs[0] = mk(0, fill(16'h3C00), fill(16'h3C00), 16'h0000, 16'h4E40, 28, "p1 ones");
        vecs[1] = mk(1, fill(16'h3C00), fill(16'h3C00), 16'h3800, 16'h4E60, 12, "p5 ones+0.5");
        vecs[2] = mk(2, onehot(24, 16'h4000), fill(16'h3C00), 16'h0000, 16'h4000, 17, "p2 pad lane");
        vecs[3] = mk(0, onehot(0, 16'h7C00), '0, 16'h0000, 16'h7E00, 28, "p1 inf*0");
        vecs[4] = mk(0, onehot(0, 16'h0001), fill(16'h3C00), 16'h0000, 16'h0000, 28, "p1 subnormal");
        vecs[5] = mk(1, fill(16'h4000), fill(16'h3800), 16'hBC00, 16'h4E00, 12, "p5 2*0.5-1");
        vecs[6] = mk(2, fill(16'h3C00), fill(16'h3C00), 16'h0000, 16'h4E40, 17, "p2 ones");
        vecs[7] = mk(0, onehot(0, 16'h3C01), onehot(0, 16'h3C01), 16'h0000, 16'h3C02, 28, "p1 mul round");
        vecs[8] = mk(0, onehot(0, 16'h1000), fill(16'h3C00), 16'h3C00, 16'h3C00, 28, "p1 tie even down");
        vecs[9] = mk(0, onehot(0, 16'h1000), fill(16'h3C00), 16'h3C01, 16'h3C02, 28, "p1 tie even up");

        reset   = 1'b1;
        start_v = '0;
        image   = '0;
        filter  = '0;
        bias    = '0;
        repeat (2) @(posedge clk);
        #1;
        for (int s = 0; s < 3; s++) begin
            check($sformatf("reset busy %0d", s), 32'(busy_v[s]), 32'd0);
            check($sformatf("reset done %0d", s), 32'(done_v[s]), 32'd0);
            check($sformatf("reset result %0d", s), 32'(res_v[s]), 32'd0);
        end
        reset = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i].sel, vecs[i].img, vecs[i].flt, vecs[i].bs,
                   vecs[i].res, vecs[i].lat, vecs[i].name);
        end

        // Starts mid-RUN and in the DONE cycle must be ignored; inputs change after acceptance.
        image  = fill(16'h3C00);
        filter = fill(16'h3C00);
        bias   = 16'h0000;
        start_v[0] = 1'b1;
        @(posedge clk); #1;
        cyc = 1; bcnt = 0; dcnt = 0; done_cyc = 0;
        while (cyc < 45) begin
            start_v[0] = 1'b0;
            if (busy_v[0]) bcnt++;
            if (cyc == 6) begin
                filter     = '0;
                start_v[0] = 1'b1;
            end
            if (done_v[0]) begin
                dcnt++;
                done_cyc   = cyc;
                start_v[0] = 1'b1;
            end
            @(posedge clk); #1;
            cyc++;
        end
        start_v[0] = 1'b0;
        check("ignore done count", 32'(dcnt), 32'd1);
        check("ignore done cycle", 32'(done_cyc), 32'd28);
        check("ignore busy cycles", 32'(bcnt), 32'd26);
        check("ignore result", 32'(res_v[0]), 32'h4E40);
        run_op(0, fill(16'h3C00), '0, 16'h0000, 16'h0000, 28, "p1 acc cleared");

        // Reset ten cycles into RUN, then a fresh operation.
        run_op(0, fill(16'h3C00), fill(16'h3C00), 16'h0000, 16'h4E40, 28, "p1 pre-reset");
        image  = fill(16'h3C00);
        filter = fill(16'h3C00);
        start_v[0] = 1'b1;
        @(posedge clk); #1;
        start_v[0] = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("midrun busy before reset", 32'(busy_v[0]), 32'd1);
        reset = 1'b1;
        #1;
        check("midrun reset busy", 32'(busy_v[0]), 32'd0);
        check("midrun reset done", 32'(done_v[0]), 32'd0);
        check("midrun reset result", 32'(res_v[0]), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        run_op(0, fill(16'h3C00), fill(16'h3C00), 16'h3C00, 16'h4E80, 28, "p1 after reset");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
